// File: rtl/fp32_pack.sv
// ---------------------------------------------------------------------------
// fp32_pack
//
// Packs a sign, a wide signed biased exponent and an unnormalized 48-bit
// magnitude into an IEEE 754 single-precision word. The value being packed
// is in_mant * 2^(in_exp - 127 - 46), so a normalized magnitude has its
// leading one at bit 46 and the 23 fraction bits directly below it.
//
// Normalization moves one bit per cycle. The result is then rounded (or
// truncated), range-checked and packed. Overflow saturates to infinity.
// Underflow flushes to a signed zero, because denormals are not produced.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   start      request pulse, sampled only while idle
//   in_sign    sign of the value
//   in_exp     10-bit signed biased exponent (bias 127)
//   in_mant    48-bit unnormalized magnitude
//   busy       high whenever an operation is in flight
//   done       one-cycle pulse, result and flags valid
//   result     packed float, held until the next done
//   overflow   result saturated to infinity, held with result
//   underflow  nonzero value flushed to zero, held with result
//
// Configuration
//   FP32_PACK_ROUND_EN  defined   -> round to nearest, ties to even
//                       undefined -> truncate (same latency)
// ---------------------------------------------------------------------------
module fp32_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        PACK  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Working copy of the operand. The exponent is 11 bits wide, so neither
    // 46 left shifts from -512 nor a rounding carry from 511 can wrap.
    logic               sign_q;
    logic signed [10:0] exp_q;
    logic [47:0]        mant_q;
    // sig_q is cleared on load. Its hidden bit (bit 23) is set only when
    // ROUND ran, so a clear hidden bit in PACK means a zero mantissa.
    logic [23:0]        sig_q;

    logic               done_q;
    logic [31:0]        result_q;
    logic               overflow_q;
    logic               underflow_q;

    logic [23:0]        round_sig;
    logic signed [10:0] round_exp;

    logic [31:0]        pack_word;
    logic               pack_ovf;
    logic               pack_unf;

`ifdef FP32_PACK_ROUND_EN
    logic               guard_bit;
    logic               sticky_bit;
    logic               round_up;
    logic [24:0]        round_sum;
`endif

    // State register. The reset is asynchronous, so an operation in flight
    // is dropped as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. NORM stays put while it shifts one bit per cycle.
    // It leaves when the leading one sits at bit 46, or at once for a zero
    // mantissa, which skips rounding entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                if (mant_q == 48'd0) begin
                    state_next = PACK;
                end else if (!mant_q[47] && mant_q[46]) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = PACK;
            end
            PACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Rounding. The significand is the 24 bits from the hidden one down.
    // With rounding enabled, guard and sticky pick round-to-nearest-even.
    // A carry out of the hidden bit gives 1.0 with the exponent bumped.
    always_comb begin
        round_sig = mant_q[46:23];
        round_exp = exp_q;
`ifdef FP32_PACK_ROUND_EN
        guard_bit  = mant_q[22];
        sticky_bit = |mant_q[21:0];
        round_up   = guard_bit & (sticky_bit | mant_q[23]);
        round_sum  = {1'b0, mant_q[46:23]} + {24'd0, round_up};
        if (round_sum[24]) begin
            round_sig = 24'h800000;
            round_exp = exp_q + 11'sd1;
        end else begin
            round_sig = round_sum[23:0];
        end
`endif
    end

    // Range check and field assembly, used on the cycle the FSM sits in PACK.
    // Zero keeps its sign and raises no flag. Out-of-range exponents saturate
    // to infinity or flush to zero.
    always_comb begin
        pack_word = {sign_q, 31'h0};
        pack_ovf  = 1'b0;
        pack_unf  = 1'b0;
        if (sig_q[23]) begin
            if (exp_q >= 11'sd255) begin
                pack_word = {sign_q, 8'hFF, 23'h0};
                pack_ovf  = 1'b1;
            end else if (exp_q <= 11'sd0) begin
                pack_unf  = 1'b1;
            end else begin
                pack_word = {sign_q, exp_q[7:0], sig_q[22:0]};
            end
        end
    end

    // Datapath and output registers. Results and flags change only when
    // leaving PACK. done is registered, so it is high in the IDLE cycle that
    // follows, and a new start can be taken in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q      <= 1'b0;
            exp_q       <= 11'sd0;
            mant_q      <= 48'd0;
            sig_q       <= 24'd0;
            done_q      <= 1'b0;
            result_q    <= 32'h0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= in_sign;
                        exp_q  <= {in_exp[9], in_exp};
                        mant_q <= in_mant;
                        sig_q  <= 24'd0;
                    end
                end
                NORM: begin
                    if (mant_q[47]) begin
                        mant_q <= {1'b0, mant_q[47:2], mant_q[1] | mant_q[0]};
                        exp_q  <= exp_q + 11'sd1;
                    end else if (!mant_q[46] && (mant_q != 48'd0)) begin
                        mant_q <= {mant_q[46:0], 1'b0};
                        exp_q  <= exp_q - 11'sd1;
                    end
                end
                ROUND: begin
                    sig_q <= round_sig;
                    exp_q <= round_exp;
                end
                PACK: begin
                    result_q    <= pack_word;
                    overflow_q  <= pack_ovf;
                    underflow_q <= pack_unf;
                    done_q      <= 1'b1;
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
